// File: rtl/simple_alu_pkg.sv
// rtl/simple_alu_pkg.sv - shared opcodes, register map, status bits and response codes for the ALU slave
package simple_alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SHL = 3'd5,
    OP_SHR = 3'd6,
    OP_MUL = 3'd7
  } alu_op_e;

  // Word indices (byte address bits [4:2]) of the register map
  localparam logic [2:0] REG_OP_A    = 3'd0;
  localparam logic [2:0] REG_OP_B    = 3'd1;
  localparam logic [2:0] REG_OPCODE  = 3'd2;
  localparam logic [2:0] REG_SCRATCH = 3'd3;
  localparam logic [2:0] REG_RESULT  = 3'd4;
  localparam logic [2:0] REG_STATUS  = 3'd5;

  localparam int STATUS_ZERO_BIT  = 0;
  localparam int STATUS_CARRY_BIT = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = strb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/simple_alu_core.sv
// rtl/simple_alu_core.sv - registered ALU: result and flags settle one cycle after operands change
module simple_alu_core
  import simple_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_e     opcode,
  output logic [31:0] result,
  output logic        zero,
  output logic        carry
);

  logic [32:0] sum;
  logic [31:0] res_next;
  logic        carry_next;

  always_comb begin
    sum        = {1'b0, a} + {1'b0, b};
    res_next   = '0;
    carry_next = 1'b0;
    case (opcode)
      OP_ADD: begin
        res_next   = sum[31:0];
        carry_next = sum[32];
      end
      OP_SUB: begin
        res_next   = a - b;
        carry_next = (a < b);
      end
      OP_AND:  res_next = a & b;
      OP_OR:   res_next = a | b;
      OP_XOR:  res_next = a ^ b;
      OP_SHL:  res_next = a << b[4:0];
      OP_SHR:  res_next = a >> b[4:0];
      OP_MUL:  res_next = a * b;
      default: res_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      result <= res_next;
      zero   <= (res_next == '0);
      carry  <= carry_next;
    end
  end

endmodule

// File: rtl/simple_alu_axil_slave.sv
// rtl/simple_alu_axil_slave.sv - AXI4-Lite register slave fronting the ALU core
module simple_alu_axil_slave
  import simple_alu_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  w_state_e w_state;
  r_state_e r_state;

  logic [3:0][31:0]               regs;
  logic                           aw_held, w_held;
  logic [C_S_AXI_ADDR_WIDTH-1:0]  aw_addr_q;
  logic [31:0]                    wdata_q;
  logic [3:0]                     wstrb_q;
  logic                           wr_ok;
  logic [31:0]                    alu_result, status, rd_data;
  logic                           alu_zero, alu_carry;
  logic [1:0]                     rd_resp;
  logic                           unused_ok;

  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, regs[REG_OPCODE[1:0]][31:3]};

  // Only the four RW registers below 0x10 accept writes
  assign wr_ok = (aw_addr_q < C_S_AXI_ADDR_WIDTH'(16));

  simple_alu_core u_core (
    .clk    (S_AXI_ACLK),
    .rst_n  (S_AXI_ARESETN),
    .a      (regs[REG_OP_A[1:0]]),
    .b      (regs[REG_OP_B[1:0]]),
    .opcode (alu_op_e'(regs[REG_OPCODE[1:0]][2:0])),
    .result (alu_result),
    .zero   (alu_zero),
    .carry  (alu_carry)
  );

  always_comb begin
    status                   = '0;
    status[STATUS_ZERO_BIT]  = alu_zero;
    status[STATUS_CARRY_BIT] = alu_carry;
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    if (S_AXI_ARADDR >= C_S_AXI_ADDR_WIDTH'(24)) begin
      rd_resp = RESP_SLVERR;
    end else begin
      case (S_AXI_ARADDR[4:2])
        REG_OP_A, REG_OP_B, REG_OPCODE, REG_SCRATCH: rd_data = regs[S_AXI_ARADDR[3:2]];
        REG_RESULT: rd_data = alu_result;
        REG_STATUS: rd_data = status;
        default:    rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state       <= W_IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      aw_addr_q     <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      regs          <= '0;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            if (wr_ok) regs[aw_addr_q[3:2]] <= apply_wstrb(regs[aw_addr_q[3:2]], wdata_q, wstrb_q);
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            S_AXI_BVALID <= 1'b1;
            w_state      <= W_RESP;
          end else begin
            // Each channel is captured once; its ready drops as soon as it is held
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
              aw_held   <= 1'b1;
              aw_addr_q <= S_AXI_AWADDR;
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
              w_held  <= 1'b1;
              wdata_q <= S_AXI_WDATA;
              wstrb_q <= S_AXI_WSTRB;
            end
            S_AXI_AWREADY <= !(aw_held || (S_AXI_AWVALID && S_AXI_AWREADY));
            S_AXI_WREADY  <= !(w_held || (S_AXI_WVALID && S_AXI_WREADY));
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= RESP_OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RDATA   <= rd_data;
            S_AXI_RRESP   <= rd_resp;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_alu_axil_slave.sv
// tb/tb_simple_alu_axil_slave.sv - scoreboard bench with directed and randomized AXI-Lite traffic
module tb_simple_alu_axil_slave;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  awaddr, araddr;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model_regs [4];
  logic [33:0] r_exp;
  logic [1:0]  b_exp;

  always #5 clk = ~clk;

  simple_alu_axil_slave dut (
    .S_AXI_ACLK   (clk),     .S_AXI_ARESETN (rst_n),
    .S_AXI_AWADDR (awaddr),  .S_AXI_AWPROT  (awprot),  .S_AXI_AWVALID (awvalid), .S_AXI_AWREADY (awready),
    .S_AXI_WDATA  (wdata),   .S_AXI_WSTRB   (wstrb),   .S_AXI_WVALID  (wvalid),  .S_AXI_WREADY  (wready),
    .S_AXI_BRESP  (bresp),   .S_AXI_BVALID  (bvalid),  .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR (araddr),  .S_AXI_ARPROT  (arprot),  .S_AXI_ARVALID (arvalid), .S_AXI_ARREADY (arready),
    .S_AXI_RDATA  (rdata),   .S_AXI_RRESP   (rresp),   .S_AXI_RVALID  (rvalid),  .S_AXI_RREADY  (rready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: no handshake within cycle budget", name);
  endtask

  // Reference model: register map and ALU rules in plain arithmetic
  function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                             input logic [3:0] strb);
    int idx;
    if (addr >= 32'd16) return 2'b10;
    idx = int'(addr / 4);
    for (int i = 0; i < 4; i++) if (strb[i]) model_regs[idx][i*8 +: 8] = data[i*8 +: 8];
    return 2'b00;
  endfunction

  function automatic logic [32:0] model_alu();
    longint unsigned a, b, r;
    logic c;
    a = 64'(model_regs[0]);
    b = 64'(model_regs[1]);
    c = 1'b0;
    case (model_regs[2] % 8)
      0:       begin r = a + b; c = (r >= 64'h1_0000_0000); end
      1:       begin r = a - b; c = (a < b); end
      2:       r = a & b;
      3:       r = a | b;
      4:       r = a ^ b;
      5:       r = a << (b % 32);
      6:       r = a >> (b % 32);
      default: r = a * b;
    endcase
    return {c, r[31:0]};
  endfunction

  function automatic logic [33:0] model_read(input logic [31:0] addr);
    logic [32:0] alu;
    alu = model_alu();
    if (addr < 32'd16) return {2'b00, model_regs[int'(addr / 4)]};
    if (addr == 32'd16) return {2'b00, alu[31:0]};
    if (addr == 32'd20) return {2'b00, 30'd0, alu[32], alu[31:0] == 32'd0};
    return {2'b10, 32'd0};
  endfunction

  always @(negedge clk) begin
    if (rst_n && rvalid && rready) begin
      if (rq.size() == 0) timeout("r_unexpected_response");
      else begin
        r_exp = rq.pop_front();
        check("rdata", rdata, r_exp[31:0]);
        check("rresp", 32'(rresp), 32'(r_exp[33:32]));
      end
    end
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) timeout("b_unexpected_response");
      else begin
        b_exp = bq.pop_front();
        check("bresp", 32'(bresp), 32'(b_exp));
      end
    end
  end

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_delay, input int b_hold, input bit abort);
    logic [1:0] er;
    bit aw_ok, w_ok, b_ok;
    er = model_write(addr, data, strb);
    if (!abort) bq.push_back(er);
    aw_ok = 0; w_ok = 0; b_ok = 0;
    fork
      begin
        wdata = data; wstrb = strb; wvalid = 1'b1;
        for (int c = 0; c < 40 && !w_ok; c++) begin
          @(negedge clk);
          if (wready) w_ok = 1;
          @(posedge clk); #1;
        end
        wvalid = 1'b0;
      end
      begin
        repeat (aw_delay) begin @(posedge clk); #1; end
        awaddr = addr[4:0]; awvalid = 1'b1;
        for (int c = 0; c < 40 && !aw_ok; c++) begin
          @(negedge clk);
          if (awready) aw_ok = 1;
          @(posedge clk); #1;
        end
        awvalid = 1'b0;
      end
    join
    if (!w_ok) timeout("w_handshake");
    if (!aw_ok) timeout("aw_handshake");
    for (int c = 0; c < 40 && !b_ok; c++) begin
      @(negedge clk);
      if (bvalid) b_ok = 1;
      else begin @(posedge clk); #1; end
    end
    if (!b_ok) begin timeout("b_valid"); return; end
    if (abort) return;
    repeat (b_hold) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bvalid_hold", 32'(bvalid), 32'd1);
    end
    @(posedge clk); #1; bready = 1'b1;
    @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp_d, input logic [1:0] exp_r);
    bit ar_ok, r_ok;
    ar_ok = 0; r_ok = 0;
    rq.push_back({exp_r, exp_d});
    araddr = addr[4:0]; arvalid = 1'b1;
    for (int c = 0; c < 40 && !ar_ok; c++) begin
      @(negedge clk);
      if (arready) ar_ok = 1;
      @(posedge clk); #1;
    end
    arvalid = 1'b0;
    if (!ar_ok) begin timeout("ar_handshake"); void'(rq.pop_back()); return; end
    rready = 1'b1;
    for (int c = 0; c < 40 && !r_ok; c++) begin
      @(negedge clk);
      if (rvalid) r_ok = 1;
      @(posedge clk); #1;
    end
    rready = 1'b0;
    if (!r_ok) timeout("r_valid");
  endtask

  task automatic read_model(input logic [31:0] addr);
    logic [33:0] e;
    e = model_read(addr);
    axi_read(addr, e[31:0], e[33:32]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    rq.delete();
    bq.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ra, rd, old_a;
    logic [3:0]  rs;
    int          kind;

    rst_n = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0; bready = 0;
    araddr = '0; arprot = '0; arvalid = 0; rready = 0;
    clear_model();

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_awready", 32'(awready), 32'd0);
    check("reset_wready",  32'(wready),  32'd0);
    check("reset_arready", 32'(arready), 32'd0);
    check("reset_bvalid",  32'(bvalid),  32'd0);
    check("reset_rvalid",  32'(rvalid),  32'd0);
    check("reset_rdata",   rdata,        32'd0);
    check("reset_bresp",   32'(bresp),   32'd0);
    check("reset_rresp",   32'(rresp),   32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("awready_before_first_edge", 32'(awready), 32'd0);
    check("arready_before_first_edge", 32'(arready), 32'd0);
    @(negedge clk);
    check("awready_after_release", 32'(awready), 32'd1);
    check("wready_after_release",  32'(wready),  32'd1);
    check("arready_after_release", 32'(arready), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) axi_write(32'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axi_read(32'(i * 4), 32'(i + 1), 2'b00);

    axi_write(32'h00, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'h1, 4'hF, 0, 0, 0);
    axi_write(32'h08, 32'h0, 4'hF, 0, 0, 0);
    axi_read(32'h10, 32'h0, 2'b00);
    axi_read(32'h14, 32'h3, 2'b00);

    axi_write(32'h00, 32'd5, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'd7, 4'hF, 0, 0, 0);
    axi_write(32'h08, 32'd1, 4'hF, 0, 0, 0);
    axi_read(32'h10, 32'hFFFF_FFFE, 2'b00);
    axi_read(32'h14, 32'h2, 2'b00);
    axi_write(32'h08, 32'd7, 4'hF, 0, 0, 0);
    axi_write(32'h00, 32'h1_0000, 4'hF, 0, 0, 0);
    axi_write(32'h04, 32'h1_0000, 4'hF, 0, 0, 0);
    axi_read(32'h10, 32'h0, 2'b00);
    axi_read(32'h14, 32'h1, 2'b00);

    axi_write(32'h0C, 32'h5A5A_1234, 4'hF, 3, 4, 0);
    axi_read(32'h0C, 32'h5A5A_1234, 2'b00);

    axi_write(32'h0C, 32'h0, 4'hF, 0, 0, 0);
    axi_write(32'h0C, 32'hAABB_CCDD, 4'b0101, 0, 0, 0);
    axi_read(32'h0C, 32'h00BB_00DD, 2'b00);
    axi_write(32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    axi_read(32'h10, 32'h0, 2'b00);
    axi_read(32'h1C, 32'h0, 2'b10);
    axi_read(32'h18, 32'h0, 2'b10);

    old_a = model_regs[0];
    fork
      axi_write(32'h00, 32'hCAFE_0001, 4'hF, 0, 0, 0);
      begin @(posedge clk); #1; axi_read(32'h00, old_a, 2'b00); end
    join
    read_model(32'h00);

    for (int i = 0; i < 60; i++) begin
      kind = int'($urandom_range(0, 2));
      ra = 32'($urandom_range(0, 7) << 2);
      rd = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom());
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      if (kind < 2) axi_write(ra, rd, rs, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0);
      else read_model(ra);
      if (i % 10 == 9) begin read_model(32'h10); read_model(32'h14); end
    end

    axi_write(32'h04, 32'h1234_5678, 4'hF, 0, 0, 1);
    #2 rst_n = 1'b0;
    #1;
    check("bvalid_async_clear",  32'(bvalid),  32'd0);
    check("awready_async_clear", 32'(awready), 32'd0);
    clear_model();
    @(posedge clk); #1 rst_n = 1'b1; bready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check("no_b_after_reset", 32'(bvalid), 32'd0);
    end
    @(posedge clk); #1 bready = 1'b0;
    for (int i = 0; i < 6; i++) read_model(32'(i * 4));
    axi_read(32'h00, 32'h0, 2'b00);

    repeat (3) @(posedge clk);
    if (rq.size() != 0 || bq.size() != 0) timeout("scoreboard_drain");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
